// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants and types for the front end.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetch FIFO entry: instruction plus the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if;
  import rv_pipe_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries. Head is read straight out of the
// storage registers, so the consumer never sees a path from the write data.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wr_data,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update; flush wins over any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a push during flush is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register. Issues in-order
// requests, reserving FIFO space for every accepted request, buffers
// responses with their PCs, and presents one {pc, inst} or a NOP per cycle.
// Optional build macro IF_PERF_EN adds saturating discard/empty counters.
module if_fetch_unit
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  if_fetch_unit_if.master imem,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst_out,
  output logic            inst_valid
`ifdef IF_PERF_EN
  ,
  output logic [31:0]     perf_discard_cnt,
  output logic [31:0]     perf_empty_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] wr_pc_q, wr_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_flight;
  logic [XLEN-1:0] redirect_tgt;
  logic            unused_redirect_lsb;
  logic            accept, drop, push, pop;
  fetch_entry_t    wr_entry, head;

  // Low address bits of the redirect target are forced to zero
  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered plus in-flight instructions must never exceed FIFO capacity
  assign in_flight     = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem.imem_req  = !rst && !redirect_valid && (in_flight < (CW+1)'(FIFO_DEPTH));
  assign imem.imem_addr = fetch_pc_q;

  assign accept = imem.imem_req && imem.imem_ready;
  // Responses to requests issued before a redirect are dropped, including
  // one that lands in the redirect cycle itself
  assign drop   = imem.imem_rvalid && (redirect_valid || (discard_q != '0));
  assign push   = imem.imem_rvalid && !drop;
  assign inst_valid = (fifo_count != '0);
  assign pop    = inst_valid && !stall && !redirect_valid;

  assign wr_entry = '{pc: wr_pc_q, inst: imem.imem_rdata};

  // Next-state for fetch PC, write-side PC and the request bookkeeping
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_pc_d       = wr_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem.imem_rvalid);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)   wr_pc_d    = wr_pc_q + 32'd4;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      wr_pc_d    = redirect_tgt;
      discard_d  = outstanding_q - CW'(imem.imem_rvalid);
    end else if (imem.imem_rvalid && (discard_q != '0)) begin
      discard_d  = discard_q - CW'(1);
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      wr_pc_q       <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_pc_q       <= wr_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .head    (head),
    .count   (fifo_count)
  );

  assign pc_out   = inst_valid ? head.pc   : '0;
  assign inst_out = inst_valid ? head.inst : NOP_INST;

`ifdef IF_PERF_EN
  logic [31:0] perf_discard_q, perf_discard_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  // Saturating event counters
  always_comb begin
    perf_discard_d = perf_discard_q;
    perf_empty_d   = perf_empty_q;
    if (drop && (perf_discard_q != '1))               perf_discard_d = perf_discard_q + 32'd1;
    if (!inst_valid && !stall && (perf_empty_q != '1)) perf_empty_d   = perf_empty_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_discard_q <= '0;
      perf_empty_q   <= '0;
    end else begin
      perf_discard_q <= perf_discard_d;
      perf_empty_q   <= perf_empty_d;
    end
  end

  assign perf_discard_cnt = perf_discard_q;
  assign perf_empty_cnt   = perf_empty_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable in-order
// instruction memory model. FIFO_DEPTH is 4.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;
`ifdef IF_PERF_EN
  logic [31:0] perf_discard_cnt;
  logic [31:0] perf_empty_cnt;
`endif

  int n_vec    = 0;
  int n_miscmp = 0;
  int mem_lat  = 1;
  int cyc      = 0;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  if_fetch_unit_if bus();

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .inst_valid     (inst_valid)
`ifdef IF_PERF_EN
    ,
    .perf_discard_cnt (perf_discard_cnt),
    .perf_empty_cnt   (perf_empty_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // In-order memory: accepted at the edge ending cycle N, answered in N+mem_lat
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (!rst && bus.imem_req && bus.imem_ready)
        mq.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
      cyc++;
      #1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_data(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("vec %0d %s ok %h", n_vec, tag, got);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
    check_vec({tag, ".valid"}, 32'(inst_valid), 32'(v));
    check_vec({tag, ".pc"},    pc_out,   v ? pc : 32'h0);
    check_vec({tag, ".inst"},  inst_out, v ? mem_data(pc) : 32'h0000_0013);
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
    check_vec({tag, ".req"}, 32'(bus.imem_req), 32'(r));
    if (r) check_vec({tag, ".addr"}, bus.imem_addr, a);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Stop issue, redirect, and let every pending response come back and drop
  task automatic resync(input logic [31:0] tgt);
    next_cycle();
    bus.imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    next_cycle();
    redirect_valid = 1'b0;
    repeat (5) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.imem_ready = 1'b1;
    mem_lat        = 1;

    // Reset state
    repeat (3) @(posedge clk);
    sample();
    check_vec("rst.req",  32'(bus.imem_req), 32'd0);
    check_vec("rst.addr", bus.imem_addr, 32'h0);
    expect_out("rst", 1'b0, 32'h0);

    // First cycle after release
    next_cycle();
    rst = 1'b0;
    sample();
    expect_req("c0", 1'b1, 32'h0);
    expect_out("c0", 1'b0, 32'h0);

    // Streaming, 1-cycle memory
    exp_pc = 32'h0;
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      sample();
      expect_req("strm", 1'b1, 32'(4 * k));
      if (k == 1) expect_out("strm", 1'b0, 32'h0);
      else begin
        expect_out("strm", 1'b1, exp_pc);
        exp_pc += 32'd4;
      end
    end

    // Stall for 5 cycles: FIFO fills, req drops, head holds; no gap after
    for (int k = 10; k <= 22; k++) begin
      next_cycle();
      stall = (k <= 14);
      sample();
      expect_out("stall", 1'b1, exp_pc);
      if (k == 10 || k == 11) expect_req("stall", 1'b1, 32'(4 * k));
      if (k >= 12 && k <= 15) expect_req("full", 1'b0, 32'h0);
      if (k == 16) expect_req("resume", 1'b1, 32'd48);
      if (!stall) exp_pc += 32'd4;
    end

    // Redirect with 1-cycle memory, target valid in R+3
    next_cycle();
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    sample();
    expect_req("redir", 1'b0, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    expect_req("redir1", 1'b1, 32'h200);
    expect_out("redir1", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_req("redir2", 1'b1, 32'h204);
    expect_out("redir2", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_req("redir3", 1'b1, 32'h208);
    expect_out("redir3", 1'b1, 32'h200);

    // Backpressure: address held, fetch PC frozen
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus.imem_ready = 1'b0;
      sample();
      expect_req("bp", 1'b1, 32'h20C);
      if (k == 0)      expect_out("bp", 1'b1, 32'h204);
      else if (k == 1) expect_out("bp", 1'b1, 32'h208);
      else             expect_out("bp", 1'b0, 32'h0);
    end
    next_cycle();
    bus.imem_ready = 1'b1;
    sample();
    expect_req("bp_rel", 1'b1, 32'h20C);
    expect_out("bp_rel", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_req("bp_rel1", 1'b1, 32'h210);
    expect_out("bp_rel1", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_out("bp_rel2", 1'b1, 32'h20C);

    // Redirect with two requests outstanding, 3-cycle memory
    resync(32'h0);
    next_cycle();
    mem_lat = 3;
    bus.imem_ready = 1'b1;
    sample();
    expect_req("l3_0", 1'b1, 32'h0);
    next_cycle();
    sample();
    expect_req("l3_1", 1'b1, 32'h4);
    next_cycle();
    bus.imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    sample();
    expect_req("l3_redir", 1'b0, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    bus.imem_ready = 1'b1;
    sample();
    expect_req("l3_tgt", 1'b1, 32'h100);
    expect_out("l3_tgt", 1'b0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      sample();
      expect_req("l3_drop", 1'b1, 32'(32'h100 + 4 * k));
      expect_out("l3_drop", 1'b0, 32'h0);
    end
    next_cycle();
    sample();
    expect_req("l3_full", 1'b0, 32'h0);
    expect_out("l3_first", 1'b1, 32'h100);
    next_cycle();
    sample();
    expect_out("l3_second", 1'b1, 32'h104);

    // Redirect while a response would fill the FIFO
    resync(32'h300);
    next_cycle();
    mem_lat = 1;
    bus.imem_ready = 1'b1;
    stall = 1'b1;
    sample();
    expect_req("sim0", 1'b1, 32'h300);
    expect_out("sim0", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_req("sim1", 1'b1, 32'h304);
    next_cycle();
    sample();
    expect_req("sim2", 1'b1, 32'h308);
    expect_out("sim2", 1'b1, 32'h300);
    next_cycle();
    sample();
    expect_req("sim3", 1'b1, 32'h30C);
    expect_out("sim3", 1'b1, 32'h300);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    sample();
    check_vec("sim_redir.rvalid", 32'(bus.imem_rvalid), 32'd1);
    expect_req("sim_redir", 1'b0, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    stall = 1'b0;
    sample();
    expect_req("sim_tgt", 1'b1, 32'h400);
    expect_out("sim_tgt", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_out("sim_tgt1", 1'b0, 32'h0);
    next_cycle();
    sample();
    expect_out("sim_tgt2", 1'b1, 32'h400);
    next_cycle();
    sample();
    expect_out("sim_tgt3", 1'b1, 32'h404);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
